// File: rtl/data_mem_ctrl.sv
// Data memory controller for a RISC-V style load/store port.
// Holds one request at a time. Stores and illegal requests answer one
// cycle after acceptance. Loads answer RD_LAT cycles after acceptance.
// The word array is not cleared by reset.
module data_mem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    // WAIT is entered with this count and exits when the count reaches zero.
    // That gives RD_LAT-1 cycles in WAIT.
    localparam logic [1:0] WAIT_INIT = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              err_p0;
    logic              we_p0;
    logic [2:0]        funct3_p0;
    logic [1:0]        lane_p0;
    logic [31:0]       word_p0;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wlanes;

    // Flags misaligned accesses, undefined funct3 codes and unsigned store codes.
    function automatic logic illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a != 2'b00;
            3'b100:  return we;
            3'b101:  return we | a[0];
            default: return 1'b1;
        endcase
    endfunction

    // Selects the byte or halfword lane and sign- or zero-extends it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    assign req_ready = rst_n & (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_err   = illegal(req_we, req_funct3, req_addr[1:0]);
    assign idx       = req_addr[ADDR_W-1:2];

    // Byte enables and lane replication for the store being presented.
    always_comb begin
        be     = 4'b0000;
        wlanes = req_wdata;
        case (req_funct3)
            3'b000: begin
                be     = 4'b0001 << req_addr[1:0];
                wlanes = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                be     = 4'b0011 << {req_addr[1], 1'b0};
                wlanes = {2{req_wdata[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Acceptance edge: latch the request, read the addressed word, commit legal stores.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_p0   <= mem[idx];
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            lane_p0   <= req_addr[1:0];
            if (req_we && !req_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    // Control state. An in-flight load is dropped when reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            err_p0 <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) err_p0 <= req_err;
        end
    end

    // Next-state logic. Stores and errors go straight to RESP; loads wait out the latency.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we || req_err || RD_LAT == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 2'd1;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & err_p0;
    assign rsp_rdata = (rsp_valid && !err_p0 && !we_p0) ? load_ext(word_p0, funct3_p0, lane_p0)
                                                        : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with two instances: RD_LAT=1 and RD_LAT=3.
module tb_data_mem_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n1, rst_n3;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_valid1, req_valid3;
    logic              req_ready1, req_ready3;
    logic              rsp_valid1, rsp_valid3;
    logic              rsp_ready1, rsp_ready3;
    logic              rsp_err1, rsp_err3;
    logic [31:0]       rsp_rdata1, rsp_rdata3;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [3:0]  lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic cur_ready(input int sel);
        return (sel == 1) ? req_ready1 : req_ready3;
    endfunction

    function automatic logic cur_valid(input int sel);
        return (sel == 1) ? rsp_valid1 : rsp_valid3;
    endfunction

    function automatic logic [31:0] cur_rdata(input int sel);
        return (sel == 1) ? rsp_rdata1 : rsp_rdata3;
    endfunction

    function automatic logic cur_err(input int sel);
        return (sel == 1) ? rsp_err1 : rsp_err3;
    endfunction

    task automatic drive_valid(input int sel, input logic v);
        if (sel == 1) req_valid1 = v;
        else          req_valid3 = v;
    endtask

    task automatic drive_rsp_ready(input int sel, input logic v);
        if (sel == 1) rsp_ready1 = v;
        else          rsp_ready3 = v;
    endtask

    // Issue one request, then check the response against the scoreboard.
    // While the DUT is busy, a conflicting store is held on the request bus.
    // Accepting it would corrupt a word that a later check reads back.
    task automatic txn(input int sel, input string tag, input logic we, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!cur_ready(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".ready_in"}, 32'(cur_ready(sel)), 32'd1);
        drive_rsp_ready(sel, hold == 0);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        drive_valid(sel, 1'b1);
        e.data = exp_d;
        e.err  = exp_e;
        e.lat  = (we || exp_e || sel == 1) ? 4'd1 : 4'd3;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = {addr[ADDR_W-1:2], 2'b00};
        req_wdata  = ~exp_d;
        n = 1;
        while (!cur_valid(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        chk({tag, ".lat"}, 32'(n), 32'(e.lat));
        chk({tag, ".data"}, cur_rdata(sel), e.data);
        chk({tag, ".err"}, 32'(cur_err(sel)), 32'(e.err));
        chk({tag, ".busy"}, 32'(cur_ready(sel)), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_v"}, 32'(cur_valid(sel)), 32'd1);
            chk({tag, ".hold_d"}, cur_rdata(sel), e.data);
            chk({tag, ".hold_rdy"}, 32'(cur_ready(sel)), 32'd0);
        end
        drive_valid(sel, 1'b0);
        drive_rsp_ready(sel, 1'b1);
        @(posedge clk); #1;
        chk({tag, ".done_v"}, 32'(cur_valid(sel)), 32'd0);
        chk({tag, ".done_rdy"}, 32'(cur_ready(sel)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        rst_n1 = 1'b0;  rst_n3 = 1'b0;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        rsp_ready1 = 1'b1; rsp_ready3 = 1'b1;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst1.valid", 32'(rsp_valid1), 32'd0);
        chk("rst1.ready", 32'(req_ready1), 32'd0);
        chk("rst1.err",   32'(rsp_err1),   32'd0);
        chk("rst1.rdata", rsp_rdata1,      32'd0);
        chk("rst3.valid", 32'(rsp_valid3), 32'd0);
        chk("rst3.ready", 32'(req_ready3), 32'd0);
        rst_n1 = 1'b1;  rst_n3 = 1'b1;
        @(posedge clk); #1;

        // Word store then load, single-cycle latency.
        txn(1, "sw_10",  1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 0, 0);
        txn(1, "lw_10",  0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);

        // Byte lanes.
        txn(1, "sw_20",  1, 3'b010, 12'h020, 32'h12345678, 32'h0, 0, 0);
        txn(1, "sb_21",  1, 3'b000, 12'h021, 32'h000000AA, 32'h0, 0, 0);
        txn(1, "lb_21",  0, 3'b000, 12'h021, 32'h0, 32'hFFFFFFAA, 0, 0);
        txn(1, "lbu_21", 0, 3'b100, 12'h021, 32'h0, 32'h000000AA, 0, 0);
        txn(1, "lw_20",  0, 3'b010, 12'h020, 32'h0, 32'h1234AA78, 0, 0);
        txn(1, "sb_23",  1, 3'b000, 12'h023, 32'h123456CC, 32'h0, 0, 0);
        txn(1, "lw_20b", 0, 3'b010, 12'h020, 32'h0, 32'hCC34AA78, 0, 0);
        txn(1, "lh_20",  0, 3'b001, 12'h020, 32'h0, 32'hFFFFAA78, 0, 0);
        txn(1, "lhu_22", 0, 3'b101, 12'h022, 32'h0, 32'h0000CC34, 0, 0);
        txn(1, "lb_20",  0, 3'b000, 12'h020, 32'h0, 32'h00000078, 0, 0);

        // Halfword lanes.
        txn(1, "sw_30",  1, 3'b010, 12'h030, 32'h55667788, 32'h0, 0, 0);
        txn(1, "sh_32",  1, 3'b001, 12'h032, 32'hABCD8001, 32'h0, 0, 0);
        txn(1, "lh_32",  0, 3'b001, 12'h032, 32'h0, 32'hFFFF8001, 0, 0);
        txn(1, "lhu_32", 0, 3'b101, 12'h032, 32'h0, 32'h00008001, 0, 0);
        txn(1, "lhu_30", 0, 3'b101, 12'h030, 32'h0, 32'h00007788, 0, 0);
        txn(1, "lw_30",  0, 3'b010, 12'h030, 32'h0, 32'h80017788, 0, 0);

        // Error cases leave memory untouched.
        txn(1, "lw_13e",  0, 3'b010, 12'h013, 32'h0, 32'h0, 1, 0);
        txn(1, "sw_00",   1, 3'b010, 12'h000, 32'hCAFEF00D, 32'h0, 0, 0);
        txn(1, "sh_01e",  1, 3'b001, 12'h001, 32'h0000BEEF, 32'h0, 1, 0);
        txn(1, "ld011e",  0, 3'b011, 12'h020, 32'h0, 32'h0, 1, 0);
        txn(1, "sbu_e",   1, 3'b100, 12'h000, 32'h00000011, 32'h0, 1, 0);
        txn(1, "shu_e",   1, 3'b101, 12'h002, 32'h00002222, 32'h0, 1, 0);
        txn(1, "lh_01e",  0, 3'b001, 12'h001, 32'h0, 32'h0, 1, 0);
        txn(1, "lhu_03e", 0, 3'b101, 12'h003, 32'h0, 32'h0, 1, 0);
        txn(1, "ld110e",  0, 3'b110, 12'h000, 32'h0, 32'h0, 1, 0);
        txn(1, "st111e",  1, 3'b111, 12'h000, 32'hFFFFFFFF, 32'h0, 1, 0);
        txn(1, "lw_00",   0, 3'b010, 12'h000, 32'h0, 32'hCAFEF00D, 0, 0);
        txn(1, "lb_03",   0, 3'b000, 12'h003, 32'h0, 32'hFFFFFFCA, 0, 0);
        txn(1, "lbu_01",  0, 3'b100, 12'h001, 32'h0, 32'h000000F0, 0, 0);
        txn(1, "lw_10b",  0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);

        // Random word stores, each followed by a signed byte read of one lane.
        for (int i = 0; i < 8; i++) begin
            logic [ADDR_W-1:0] a;
            logic [31:0]       d;
            logic [1:0]        ln;
            logic [7:0]        b;
            a  = {10'($urandom_range(64, 1023)), 2'b00};
            d  = $urandom;
            ln = 2'($urandom_range(0, 3));
            b  = 8'(d >> (8 * ln));
            txn(1, "rnd_sw", 1, 3'b010, a, d, 32'h0, 0, 0);
            txn(1, "rnd_lb", 0, 3'b000, a | ADDR_W'(ln), 32'h0, {{24{b[7]}}, b}, 0, 0);
        end

        // Three-cycle latency with back-pressure on the response.
        txn(3, "l3_sw40",  1, 3'b010, 12'h040, 32'hA5A50F0F, 32'h0, 0, 0);
        txn(3, "l3_lw40h", 0, 3'b010, 12'h040, 32'h0, 32'hA5A50F0F, 0, 5);
        txn(3, "l3_lbu43", 0, 3'b100, 12'h043, 32'h0, 32'h000000A5, 0, 0);
        txn(3, "l3_lh40",  0, 3'b001, 12'h040, 32'h0, 32'h00000F0F, 0, 0);
        txn(3, "l3_sb42",  1, 3'b000, 12'h042, 32'h00000077, 32'h0, 0, 0);
        txn(3, "l3_lw40",  0, 3'b010, 12'h040, 32'h0, 32'hA5770F0F, 0, 0);
        txn(3, "l3_err",   0, 3'b010, 12'h042, 32'h0, 32'h0, 1, 2);

        // Reset while a load sits in WAIT: the load is discarded.
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h040; req_wdata = '0;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(posedge clk); #1;
        rst_n3 = 1'b0;
        #1;
        chk("wrst.valid", 32'(rsp_valid3), 32'd0);
        chk("wrst.ready", 32'(req_ready3), 32'd0);
        chk("wrst.rdata", rsp_rdata3, 32'd0);
        chk("wrst.err",   32'(rsp_err3), 32'd0);
        #2;
        rst_n3 = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid3) ok = 1'b0;
        end
        chk("wrst.no_rsp", 32'(ok), 32'd1);
        chk("wrst.ready_after", 32'(req_ready3), 32'd1);
        txn(3, "l3_after_rst", 0, 3'b010, 12'h040, 32'h0, 32'hA5770F0F, 0, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
